// File: rtl/demux1_4_dispatcher.sv
// demux1_4_dispatcher
// Front-end sequencer for a 1:4 demux datapath. Takes words from a single
// valid/ready source and picks a destination for each one, either from
// in_dest (addressed mode) or from a rotating pointer (round-robin mode).
// Each word is held on select/out_data until the chosen sink accepts it.
// A word whose sink stalls for TIMEOUT consecutive cycles is dropped and
// counted.
module demux1_4_dispatcher #(
  parameter int DATA_W  = 4,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_dest,
  input  logic [DATA_W-1:0] in_data,
  output logic [1:0]        select,
  output logic [DATA_W-1:0] out_data,
  output logic [3:0]        out_valid,
  input  logic [3:0]        out_ready,
  output logic              busy,
  output logic              drop_pulse,
  output logic [CNT_W-1:0]  drop_count
);

  // The stall counter only has to reach TIMEOUT-1; with TIMEOUT==0 it
  // simply saturates and is never compared against a limit.
  localparam int WC_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic [WC_W-1:0] WC_MAX  = {WC_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  logic [0:0]        state_q,      state_d;
  logic [1:0]        select_q,     select_d;
  logic [DATA_W-1:0] data_q,       data_d;
  logic [1:0]        rr_ptr_q,     rr_ptr_d;
  logic [WC_W-1:0]   wait_cnt_q,   wait_cnt_d;
  logic              drop_pulse_q, drop_pulse_d;
  logic [CNT_W-1:0]  drop_count_q, drop_count_d;

  logic sending_s;
  logic acc_s;
  logic expire_s;
  logic in_ready_s;
  logic cap_s;

  // Handshake decode: sink acceptance, timeout expiry and source readiness.
  // in_ready follows out_ready combinationally so a delivery and a new
  // capture can share a cycle (one word per cycle).
  always_comb begin
    sending_s  = (state_q == S_SEND);
    acc_s      = sending_s & out_ready[select_q];
    expire_s   = 1'b0;
    if (TIMEOUT != 0) begin
      expire_s = sending_s & ~acc_s & (wait_cnt_q == WC_LAST);
    end else begin
      expire_s = 1'b0;
    end
    in_ready_s = (state_q == S_IDLE) | acc_s;
    cap_s      = in_valid & in_ready_s;
  end

  // Next-state computation for the sequencer and its bookkeeping registers.
  always_comb begin
    state_d      = state_q;
    select_d     = select_q;
    data_d       = data_q;
    rr_ptr_d     = rr_ptr_q;
    wait_cnt_d   = wait_cnt_q;
    drop_pulse_d = 1'b0;
    drop_count_d = drop_count_q;

    if (cap_s) begin
      // New word: destination and round-robin advance are fixed here, so a
      // later mode change cannot redirect a word already held.
      data_d     = in_data;
      wait_cnt_d = {WC_W{1'b0}};
      state_d    = S_SEND;
      if (mode) begin
        select_d = rr_ptr_q;
        rr_ptr_d = rr_ptr_q + 2'd1;
      end else begin
        select_d = in_dest;
        rr_ptr_d = rr_ptr_q;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_IDLE;
        end
        S_SEND: begin
          if (acc_s) begin
            state_d = S_IDLE;
          end else if (expire_s) begin
            state_d      = S_IDLE;
            drop_pulse_d = 1'b1;
            if (drop_count_q != CNT_MAX) begin
              drop_count_d = drop_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
              drop_count_d = drop_count_q;
            end
          end else begin
            state_d = S_SEND;
            if (wait_cnt_q != WC_MAX) begin
              wait_cnt_d = wait_cnt_q + {{(WC_W-1){1'b0}}, 1'b1};
            end else begin
              wait_cnt_d = wait_cnt_q;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State registers; reset discards any held word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      select_q     <= 2'd0;
      data_q       <= {DATA_W{1'b0}};
      rr_ptr_q     <= 2'd0;
      wait_cnt_q   <= {WC_W{1'b0}};
      drop_pulse_q <= 1'b0;
      drop_count_q <= {CNT_W{1'b0}};
    end else begin
      state_q      <= state_d;
      select_q     <= select_d;
      data_q       <= data_d;
      rr_ptr_q     <= rr_ptr_d;
      wait_cnt_q   <= wait_cnt_d;
      drop_pulse_q <= drop_pulse_d;
      drop_count_q <= drop_count_d;
    end
  end

  // One-hot valid decode from registered state only, so it can never be
  // multi-hot and never depends on sink inputs.
  always_comb begin
    out_valid = 4'b0000;
    if (state_q == S_SEND) begin
      case (select_q)
        2'd0:    out_valid = 4'b0001;
        2'd1:    out_valid = 4'b0010;
        2'd2:    out_valid = 4'b0100;
        2'd3:    out_valid = 4'b1000;
        default: out_valid = 4'b0000;
      endcase
    end else begin
      out_valid = 4'b0000;
    end
  end

  assign in_ready   = in_ready_s;
  assign select     = select_q;
  assign out_data   = data_q;
  assign busy       = (state_q == S_SEND);
  assign drop_pulse = drop_pulse_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_demux1_4_dispatcher.sv
// Testbench for demux1_4_dispatcher: directed scenarios plus randomized
// traffic checked against a transaction-level reference model.
module tb_demux1_4_dispatcher;

  localparam int TO       = 15;
  localparam int DROP_MAX = 255;
  localparam int TO_B     = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  // Main instance (default parameters)
  logic       mode = 1'b0, in_valid = 1'b0, in_ready;
  logic [1:0] in_dest = 2'd0, select;
  logic [3:0] in_data = 4'd0, out_data, out_valid, out_ready = 4'd0;
  logic       busy, drop_pulse;
  logic [7:0] drop_count;

  // Saturation instance (CNT_W=2, short timeout)
  logic       in_valid_b = 1'b0, in_ready_b;
  logic [1:0] select_b;
  logic [3:0] out_data_b, out_valid_b, out_ready_b = 4'd0;
  logic       busy_b, drop_pulse_b;
  logic [1:0] drop_count_b;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: is a word held, where to, what, how long stalled
  bit m_hold;
  int m_dest, m_rr, m_stalls, m_drops;
  logic [3:0] m_data;
  bit m_pulse;

  always #5 clk = ~clk;

  demux1_4_dispatcher u_dut (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_dest(in_dest), .in_data(in_data), .select(select), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .drop_pulse(drop_pulse), .drop_count(drop_count)
  );

  demux1_4_dispatcher #(.DATA_W(4), .TIMEOUT(TO_B), .CNT_W(2)) u_dut_sat (
    .clk(clk), .rst(rst), .mode(1'b0), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_dest(2'd1), .in_data(4'h9), .select(select_b), .out_data(out_data_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .busy(busy_b),
    .drop_pulse(drop_pulse_b), .drop_count(drop_count_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_hold = 0; m_dest = 0; m_rr = 0; m_stalls = 0; m_drops = 0;
    m_data = 4'd0; m_pulse = 0;
  endtask

  // Compare all outputs of the main instance against the model's view
  task automatic check_outputs();
    logic [3:0] exp_valid;
    exp_valid = m_hold ? (4'b0001 << m_dest) : 4'b0000;
    chk("in_ready", {31'd0, in_ready}, {31'd0, (!m_hold || out_ready[m_dest])});
    chk("out_valid", {28'd0, out_valid}, {28'd0, exp_valid});
    chk("busy", {31'd0, busy}, {31'd0, m_hold});
    chk("drop_pulse", {31'd0, drop_pulse}, {31'd0, m_pulse});
    chk("drop_count", {24'd0, drop_count}, m_drops);
    if (m_hold) begin
      chk("select", {30'd0, select}, m_dest);
      chk("out_data", {28'd0, out_data}, {28'd0, m_data});
    end
  endtask

  // Apply the effect of one clock edge to the model, using the current inputs
  task automatic model_edge();
    bit acc, cap, drp;
    acc = m_hold && out_ready[m_dest];
    cap = in_valid && (!m_hold || acc);
    drp = m_hold && !acc && (TO != 0) && (m_stalls + 1 == TO);
    m_pulse = drp;
    if (drp && m_drops < DROP_MAX) m_drops++;
    if (cap) begin
      m_hold = 1; m_data = in_data; m_stalls = 0;
      m_dest = mode ? m_rr : int'(in_dest);
      if (mode) m_rr = (m_rr + 1) % 4;
    end else if (acc || drp) begin
      m_hold = 0;
    end else if (m_hold) begin
      m_stalls++;
    end
  endtask

  // One cycle: drive inputs after the falling edge, check, then model the edge
  task automatic step(input logic v, input logic [1:0] d, input logic [3:0] dat,
                      input logic md, input logic [3:0] rdy);
    @(negedge clk);
    in_valid = v; in_dest = d; in_data = dat; mode = md; out_ready = rdy;
    #1;
    check_outputs();
    model_edge();
  endtask

  initial begin
    int stall_left;
    logic [3:0] rdy;
    model_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset in the middle of a transfer to sink 2
    step(1'b1, 2'd2, 4'h7, 1'b0, 4'b0000);
    step(1'b0, 2'd0, 4'h0, 1'b0, 4'b0000);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_out_valid", {28'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_select", {30'd0, select}, 32'd0);
    chk("rst_out_data", {28'd0, out_data}, 32'd0);
    chk("rst_drop_count", {24'd0, drop_count}, 32'd0);
    chk("rst_drop_pulse", {31'd0, drop_pulse}, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 2'd0, 4'h0, 1'b0, 4'b0100);
    step(1'b0, 2'd0, 4'h0, 1'b0, 4'b0100);

    // Addressed mode, back-to-back to sinks 0..3
    for (int i = 0; i < 4; i++) step(1'b1, 2'(i), 4'hF, 1'b0, 4'b1111);
    step(1'b0, 2'd0, 4'h0, 1'b0, 4'b1111);

    // Round-robin mode: in_dest ignored, pointer wraps
    for (int i = 0; i < 6; i++) step(1'b1, 2'd3, 4'(4'hA + i), 1'b1, 4'b1111);
    step(1'b0, 2'd0, 4'h0, 1'b1, 4'b1111);

    // Stall on sink 2 for 5 cycles; other sinks ready but must be ignored
    step(1'b1, 2'd2, 4'h5, 1'b0, 4'b1111);
    for (int i = 0; i < 5; i++) step(1'b1, 2'd1, 4'h6, 1'b0, 4'b1011);
    step(1'b0, 2'd0, 4'h0, 1'b0, 4'b0100);
    step(1'b0, 2'd0, 4'h0, 1'b0, 4'b0000);

    // Timeout: 15 stalled cycles, then drop and a one-cycle pulse
    step(1'b1, 2'd3, 4'h8, 1'b0, 4'b0000);
    for (int i = 0; i < 17; i++) step(1'b0, 2'd0, 4'h0, 1'b0, 4'b0000);

    // Ready arriving in the 15th stalled cycle wins over the timeout
    step(1'b1, 2'd2, 4'h3, 1'b0, 4'b0000);
    for (int i = 0; i < 14; i++) step(1'b0, 2'd0, 4'h0, 1'b0, 4'b0000);
    step(1'b0, 2'd0, 4'h0, 1'b0, 4'b0100);
    step(1'b0, 2'd0, 4'h0, 1'b0, 4'b0000);

    // Randomized traffic with occasional long all-stall windows
    stall_left = 0;
    for (int c = 0; c < 800; c++) begin
      if (stall_left == 0 && $urandom_range(0, 60) == 0) stall_left = $urandom_range(10, 22);
      if (stall_left > 0) begin
        rdy = 4'b0000;
        stall_left--;
      end else begin
        rdy = 4'($urandom);
      end
      step(1'($urandom_range(0, 3) != 0), 2'($urandom), 4'($urandom),
           1'($urandom), rdy);
    end

    // Saturation instance: continuous stalled traffic, drop every 4 cycles
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 28; c++) begin
      if (c > 0) @(negedge clk);
      in_valid_b = 1'b1; out_ready_b = 4'b0000;
      #1;
      chk("sat_drop_pulse", {31'd0, drop_pulse_b}, {31'd0, (c > 0 && c % 4 == 0)});
      chk("sat_drop_count", {30'd0, drop_count_b}, (c / 4 > 3) ? 3 : c / 4);
      chk("sat_busy", {31'd0, busy_b}, {31'd0, (c % 4 != 0)});
      if (c % 4 != 0) begin
        chk("sat_out_valid", {28'd0, out_valid_b}, 32'h2);
        chk("sat_select", {30'd0, select_b}, 32'd1);
        chk("sat_out_data", {28'd0, out_data_b}, 32'h9);
      end
      chk("sat_in_ready", {31'd0, in_ready_b}, {31'd0, (c % 4 == 0)});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
